// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - byte-wide RAM/IO port arbiter between instruction fetch and load/store buffer
// Optional IO store throttling: MEM_ARB_IO_THROTTLE_EN
module mem_bus_arbiter #(
    parameter int         POS_W = 4,
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             io_buffer_full,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_ready,
    output logic [31:0]      if_data,
    input  logic             d_req,
    input  logic [POS_W-1:0] d_pos,
    input  logic             d_we,
    input  logic [1:0]       d_size,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_ready,
    output logic [31:0]      d_rdata,
    output logic [POS_W-1:0] d_pos_out,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    output logic             busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
`ifdef MEM_ARB_IO_THROTTLE_EN
    localparam logic [1:0] S_IO_WAIT = 2'd3;
`endif

    logic [1:0]       state;
    logic [2:0]       beat;
    logic [1:0]       last;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [POS_W-1:0] pos;
    logic             is_data;
    logic [31:0]      rbuf;

    logic [1:0]  d_last;
    logic [1:0]  cap_idx;
    logic [31:0] next_buf;
    logic        is_io;

    always_comb begin
        case (d_size)
            2'd0:    d_last = 2'd0;
            2'd1:    d_last = 2'd1;
            default: d_last = 2'd3;
        endcase
    end

    // Read data lags its address by one beat, so beat k captures byte k-1.
    always_comb begin
        next_buf = rbuf;
        cap_idx  = 2'(beat - 3'd1);
        next_buf[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    assign is_io = (d_addr[17:16] == IO_HI);

`ifndef MEM_ARB_IO_THROTTLE_EN
    logic unused_io;
    assign unused_io = io_buffer_full | is_io;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_IDLE;
            beat      <= 3'd0;
            last      <= 2'd0;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            pos       <= '0;
            is_data   <= 1'b0;
            rbuf      <= 32'd0;
            if_ready  <= 1'b0;
            if_data   <= 32'd0;
            d_ready   <= 1'b0;
            d_rdata   <= 32'd0;
            d_pos_out <= '0;
        end else if (rdy_in) begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Requesters drop req only after seeing ready, so skip the pulse cycle.
                    if (!clear && !if_ready && !d_ready && (d_req || if_req)) begin
                        beat <= 3'd0;
                        rbuf <= 32'd0;
                        if (d_req) begin
                            is_data <= 1'b1;
                            addr    <= d_addr;
                            pos     <= d_pos;
                            wdata   <= d_wdata;
                            last    <= d_last;
                            if (!d_we)
                                state <= S_READ;
`ifdef MEM_ARB_IO_THROTTLE_EN
                            else if (is_io && io_buffer_full)
                                state <= S_IO_WAIT;
`endif
                            else
                                state <= S_WRITE;
                        end else begin
                            is_data <= 1'b0;
                            addr    <= if_addr;
                            last    <= 2'd3;
                            state   <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (clear) begin
                        state <= S_IDLE;
                    end else begin
                        if (beat != 3'd0)
                            rbuf <= next_buf;
                        if (beat == {1'b0, last} + 3'd1) begin
                            state <= S_IDLE;
                            if (is_data) begin
                                d_ready   <= 1'b1;
                                d_rdata   <= next_buf;
                                d_pos_out <= pos;
                            end else begin
                                if_ready <= 1'b1;
                                if_data  <= next_buf;
                            end
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    // Stores are committed; clear never cuts them short.
                    if (beat[1:0] == last) begin
                        state     <= S_IDLE;
                        d_ready   <= 1'b1;
                        d_pos_out <= pos;
                    end else begin
                        beat <= beat + 3'd1;
                    end
                end
`ifdef MEM_ARB_IO_THROTTLE_EN
                S_IO_WAIT: begin
                    if (!io_buffer_full)
                        state <= S_WRITE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        if ((state == S_READ || state == S_WRITE) && !beat[2] && beat[1:0] <= last)
            mem_a = addr + {29'd0, beat};
        if (state == S_WRITE)
            mem_dout = wdata[{beat[1:0], 3'b000} +: 8];
    end

    assign mem_wr = rdy_in && (state == S_WRITE);
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        d_req = 1'b0;
    logic [3:0]  d_pos = 4'd0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [3:0]  d_pos_out;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        busy;

    logic [7:0] ram [0:65535];
    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int cyc;
    int w0;

    mem_bus_arbiter #(.POS_W(4), .IO_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .d_req(d_req), .d_pos(d_pos), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .d_pos_out(d_pos_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM; the whole system freezes with rdy_in, so the read register does too.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) begin
                ram[mem_a[15:0]] <= mem_dout;
                wr_cnt <= wr_cnt + 1;
            end
            mem_din <= ram[mem_a[15:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ready(input bit want_d, output int n);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (want_d ? d_ready : if_ready) break;
        end
    endtask

    task automatic data_req(input bit we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] p);
        d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_pos = p;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0010] = 8'h34; ram[16'h0011] = 8'h12;
        ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22;
        ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;

        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mem_a", mem_a, 32'd0);
        check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        check_eq("rst_if_data", if_data, 32'd0);
        check_eq("rst_d_rdata", d_rdata, 32'd0);
        rst_in = 1'b1;
        tick();

        // Word fetch
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check_eq("fetch_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check_eq("fetch_mem_a", mem_a, 32'h100 + k);
            check_eq("fetch_mem_wr", {31'd0, mem_wr}, 32'd0);
            tick();
        end
        check_eq("fetch_early", {31'd0, if_ready}, 32'd0);
        tick();
        check_eq("fetch_ready", {31'd0, if_ready}, 32'd1);
        check_eq("fetch_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        tick();
        check_eq("fetch_pulse", {31'd0, if_ready}, 32'd0);
        check_eq("fetch_idle", {31'd0, busy}, 32'd0);

        // Byte store
        data_req(1'b1, 2'd0, 32'h2000, 32'h0000_00AB, 4'd5);
        tick();
        check_eq("bst_wr", {31'd0, mem_wr}, 32'd1);
        check_eq("bst_dout", {24'd0, mem_dout}, 32'hAB);
        check_eq("bst_a", mem_a, 32'h2000);
        tick();
        check_eq("bst_ready", {31'd0, d_ready}, 32'd1);
        check_eq("bst_pos", {28'd0, d_pos_out}, 32'd5);
        check_eq("bst_wr_done", {31'd0, mem_wr}, 32'd0);
        check_eq("bst_ram", {24'd0, ram[16'h2000]}, 32'hAB);
        d_req = 1'b0;
        tick();

        // Half load contends with fetch; data wins
        data_req(1'b0, 2'd1, 32'h10, 32'd0, 4'd7);
        if_req = 1'b1; if_addr = 32'h100;
        wait_ready(1'b1, cyc);
        check_eq("hl_cycles", cyc, 32'd4);
        check_eq("hl_rdata", d_rdata, 32'h0000_1234);
        check_eq("hl_pos", {28'd0, d_pos_out}, 32'd7);
        check_eq("hl_no_if", {31'd0, if_ready}, 32'd0);
        d_req = 1'b0;
        tick();
        check_eq("no_grant_on_pulse", {31'd0, busy}, 32'd0);
        tick();
        check_eq("fetch2_a", mem_a, 32'h100);
        wait_ready(1'b0, cyc);
        check_eq("fetch2_cycles", cyc, 32'd5);
        check_eq("fetch2_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        tick();

        // Clear during fetch beat 2
        if_req = 1'b1; if_addr = 32'h200;
        tick(); tick(); tick();
        check_eq("clr_beat2_a", mem_a, 32'h202);
        clear = 1'b1;
        tick();
        clear = 1'b0; if_req = 1'b0;
        check_eq("clr_busy", {31'd0, busy}, 32'd0);
        w0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (if_ready) w0++;
            tick();
        end
        check_eq("clr_no_ready", w0, 32'd0);

        // Clear blocks a same-cycle grant
        if_req = 1'b1; clear = 1'b1;
        tick();
        check_eq("clr_blocks_grant", {31'd0, busy}, 32'd0);
        if_req = 1'b0; clear = 1'b0;
        tick();

        // Word store survives clear at beat 1
        w0 = wr_cnt;
        data_req(1'b1, 2'd2, 32'h3000, 32'hDEAD_BEEF, 4'd3);
        tick(); tick();
        clear = 1'b1;
        wait_ready(1'b1, cyc);
        clear = 1'b0;
        check_eq("wst_cycles", cyc, 32'd3);
        check_eq("wst_pos", {28'd0, d_pos_out}, 32'd3);
        check_eq("wst_count", wr_cnt - w0, 32'd4);
        check_eq("wst_ram", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();

        // IO store with buffer full
        w0 = wr_cnt;
        io_buffer_full = 1'b1;
        data_req(1'b1, 2'd0, 32'h0003_0000, 32'h41, 4'd1);
        tick();
`ifdef MEM_ARB_IO_THROTTLE_EN
        for (int i = 0; i < 3; i++) begin
            check_eq("io_wait_wr", {31'd0, mem_wr}, 32'd0);
            check_eq("io_wait_busy", {31'd0, busy}, 32'd1);
            if (i < 2) tick();
        end
        io_buffer_full = 1'b0;
        tick();
`endif
        check_eq("io_wr", {31'd0, mem_wr}, 32'd1);
        check_eq("io_dout", {24'd0, mem_dout}, 32'h41);
        tick();
        check_eq("io_ready", {31'd0, d_ready}, 32'd1);
        check_eq("io_count", wr_cnt - w0, 32'd1);
        d_req = 1'b0; io_buffer_full = 1'b0;
        tick();

        // Freeze two cycles mid-load
        data_req(1'b0, 2'd2, 32'h200, 32'd0, 4'd9);
        tick(); tick();
        rdy_in = 1'b0;
        tick(); tick();
        check_eq("frz_mem_a", mem_a, 32'h201);
        rdy_in = 1'b1;
        wait_ready(1'b1, cyc);
        check_eq("frz_cycles", cyc, 32'd4);
        check_eq("frz_rdata", d_rdata, 32'h4433_2211);
        d_req = 1'b0;
        tick();

        // Store frozen then reset mid-transfer
        w0 = wr_cnt;
        data_req(1'b1, 2'd2, 32'h4000, 32'h0102_0304, 4'd2);
        tick();
        rdy_in = 1'b0;
        #1;
        check_eq("frz_st_wr", {31'd0, mem_wr}, 32'd0);
        rdy_in = 1'b1;
        tick();
        #2 rst_in = 1'b0;
        #1;
        check_eq("arst_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_a", mem_a, 32'd0);
        check_eq("arst_dout", {24'd0, mem_dout}, 32'd0);
        check_eq("arst_ready", {31'd0, d_ready}, 32'd0);
        d_req = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        check_eq("arst_idle", {31'd0, busy}, 32'd0);
        check_eq("arst_count", wr_cnt - w0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
